// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sseg_scan_ctrl_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam int DIGIT_W          = 4;
    localparam int IDX_W            = 3;
    localparam int DEFAULT_TICK_DIV = 100000;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             wrap;
    } scan_step_t;

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module sseg_tick_gen #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit scan controller with frame-boundary double buffering.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int CNT_W    = 17
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [IDX_W-1:0]              active,
    output logic [DIGIT_W-1:0]            num,
    output logic                          dp_ctrl,
    output logic                          frame_done,
    output logic                          update_ack
);

    localparam int VAL_W = NUM_DIGITS * DIGIT_W;

    // Wrap is flagged when the search crosses from the last digit to 0.
    function automatic scan_step_t next_digit(
        input logic [IDX_W-1:0]      cur,
        input logic [NUM_DIGITS-1:0] en
    );
        scan_step_t     r;
        logic           found;
        logic [IDX_W:0] pos;
        r.idx = '0;
        r.wrap = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            pos = {1'b0, cur} + (IDX_W + 1)'(i);
            if (!found && en[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                r.idx = pos[IDX_W-1:0];
                r.wrap = pos[IDX_W];
            end
        end
        return r;
    endfunction

    logic                  tick;
    scan_step_t            step;
    logic                  wrap, commit;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
    logic [VAL_W-1:0]      pnd_val_q, pnd_val_d;
    logic [NUM_DIGITS-1:0] pnd_dp_q, pnd_dp_d;
    logic                  pnd_q, pnd_d;
    logic                  fd_q, fd_d;
    logic                  ack_q, ack_d;

    sseg_tick_gen #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(reset_n),
        .tick_o(tick)
    );

    assign step   = next_digit(idx_q, digit_en);
    assign wrap   = tick & step.wrap;
    assign commit = wrap & pnd_q;

    always_comb begin
        idx_d     = idx_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        pnd_val_d = pnd_val_q;
        pnd_dp_d  = pnd_dp_q;
        pnd_d     = pnd_q;
        fd_d      = wrap;
        ack_d     = commit;
        if (tick) idx_d = step.idx;
        if (commit) begin
            shd_val_d = pnd_val_q;
            shd_dp_d  = pnd_dp_q;
            pnd_d     = 1'b0;
        end
        // A load on the commit cycle refills pending for the next frame.
        if (load) begin
            pnd_val_d = value;
            pnd_dp_d  = dp_in;
            pnd_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            pnd_val_q <= '0;
            pnd_dp_q  <= '0;
            pnd_q     <= 1'b0;
            fd_q      <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            pnd_val_q <= pnd_val_d;
            pnd_dp_q  <= pnd_dp_d;
            pnd_q     <= pnd_d;
            fd_q      <= fd_d;
            ack_q     <= ack_d;
        end
    end

    assign active     = idx_q;
    assign num        = shd_val_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dp_ctrl    = ~shd_dp_q[idx_q];
    assign frame_done = fd_q;
    assign update_ack = ack_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl at TICK_DIV = 4.
module tb_sseg_scan_ctrl;

    typedef struct {
        logic [7:0]  en;
        logic        ld;
        logic [31:0] val;
        logic [7:0]  dp;
        logic [2:0]  act;
        logic [3:0]  nm;
        logic        dpc;
        logic        fd;
        logic        ua;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic [2:0]  active;
    logic [3:0]  num;
    logic        dp_ctrl;
    logic        frame_done;
    logic        update_ack;

    int total = 0;
    int bad = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .active    (active),
        .num       (num),
        .dp_ctrl   (dp_ctrl),
        .frame_done(frame_done),
        .update_ack(update_ack)
    );

    task automatic chk(input string nm, input logic [2:0] a, input logic [3:0] n,
                       input logic d, input logic f, input logic u);
        total++;
        if (active !== a || num !== n || dp_ctrl !== d ||
            frame_done !== f || update_ack !== u) begin
            bad++;
            $display("FAIL %s: got act=%0d num=%h dp=%b fd=%b ua=%b want act=%0d num=%h dp=%b fd=%b ua=%b",
                     nm, active, num, dp_ctrl, frame_done, update_ack, a, n, d, f, u);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] en, input logic ld,
                                input logic [31:0] val, input logic [7:0] dp,
                                input logic [2:0] a, input logic [3:0] n,
                                input logic d, input logic f, input logic u);
        vec_t v;
        v.en = en; v.ld = ld; v.val = val; v.dp = dp;
        v.act = a; v.nm = n; v.dpc = d; v.fd = f; v.ua = u;
        return v;
    endfunction

    initial begin
        for (int i = 1; i < 8; i++)
            vt.push_back(mk(8'hFF, 0, 0, 0, 3'(i), 4'h0, 1, 0, 0));
        vt.push_back(mk(8'hFF, 0, 0, 0, 3'd0, 4'h0, 1, 1, 0));
        vt.push_back(mk(8'hFF, 1, 32'h76543210, 8'h01, 3'd1, 4'h0, 1, 0, 0));
        for (int i = 2; i < 8; i++)
            vt.push_back(mk(8'hFF, 0, 0, 0, 3'(i), 4'h0, 1, 0, 0));
        vt.push_back(mk(8'hFF, 0, 0, 0, 3'd0, 4'h0, 0, 1, 1));
        for (int i = 1; i < 8; i++)
            vt.push_back(mk(8'hFF, 0, 0, 0, 3'(i), 4'(i), 1, 0, 0));
        vt.push_back(mk(8'hFF, 0, 0, 0, 3'd0, 4'h0, 0, 1, 0));
        vt.push_back(mk(8'h85, 0, 0, 0, 3'd2, 4'h2, 1, 0, 0));
        vt.push_back(mk(8'h85, 0, 0, 0, 3'd7, 4'h7, 1, 0, 0));
        vt.push_back(mk(8'h85, 0, 0, 0, 3'd0, 4'h0, 0, 1, 0));
        vt.push_back(mk(8'h10, 0, 0, 0, 3'd4, 4'h4, 1, 0, 0));
        vt.push_back(mk(8'h10, 1, 32'h89ABCDEF, 8'h10, 3'd4, 4'hB, 0, 1, 1));
        vt.push_back(mk(8'h10, 0, 0, 0, 3'd4, 4'hB, 0, 1, 0));

        #12;
        chk("reset", 3'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vt[k]) begin
            digit_en = vt[k].en;
            if (vt[k].ld) begin
                load = 1'b1;
                value = vt[k].val;
                dp_in = vt[k].dp;
            end
            cyc();
            load = 1'b0;
            repeat (3) cyc();
            chk($sformatf("vec%0d", k), vt[k].act, vt[k].nm, vt[k].dpc, vt[k].fd, vt[k].ua);
        end

        // Load A, then load B exactly on the wrap-tick cycle.
        load = 1'b1; value = 32'h11111111; dp_in = 8'h00;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        load = 1'b1; value = 32'h22222222;
        cyc();
        load = 1'b0;
        chk("wrapA", 3'd4, 4'h1, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("pulse_one", 3'd4, 4'h1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("wrapB", 3'd4, 4'h2, 1'b1, 1'b1, 1'b1);

        // Reset mid-frame with a pending load.
        load = 1'b1; value = 32'h33333333; dp_in = 8'hFF;
        cyc();
        load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", 3'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        digit_en = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("post_rst_hold", 3'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            repeat (4) cyc();
            if (i == 1) cyc();
            if (i == 1) repeat (3) cyc();
            if (i == 1) chk("post_rst_s2", 3'd2, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("post_rst_wrap", 3'd1, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 8-digit seven-segment display.
- Holds a 32-bit hex value (8 nibbles) plus 8 decimal-point bits, and steps a digit index at a fixed refresh rate.
- Drives the single-digit sseg driver's active/num/dp_ctrl inputs directly, so each digit is lit in turn.
- New values are double-buffered and only committed at a frame boundary, so the display never tears.

Parameters:
- TICK_DIV, 100000: clk cycles per digit slot (100 MHz gives 1 kHz per digit); must be >= 2.
- CNT_W, 17: width of the prescaler counter; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; captures value/dp_in into the pending buffer.
- value  input  32  hex digits; nibble k (value[4k+3:4k]) is shown on digit k.
- dp_in  input  8  decimal-point request per digit; 1 = lit.
- digit_en  input  8  per-digit scan enable; disabled digits are skipped.
- active  output  3  index of the digit currently driven.
- num  output  4  nibble for the active digit.
- dp_ctrl  output  1  decimal point for the active digit; active-low (0 = lit).
- frame_done  output  1  one-cycle pulse on each scan wrap.
- update_ack  output  1  one-cycle pulse when pending data is committed to the display.

Behaviour:
- Reset (async assert, sync-release use):
  - prescaler = 0, idx = 0, shadow value = 0, shadow dp = 0, pending flag = 0.
  - Resulting outputs: active = 0, num = 0, dp_ctrl = 1, frame_done = 0, update_ack = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when count == TICK_DIV-1.
- Scan step on tick:
  - idx moves to the first enabled digit found searching idx+1, idx+2, ... modulo 8.
  - Wrap: the search passes from 7 to 0 (including landing back on the same idx when only one digit is enabled).
  - digit_en == 0: idx goes to 0 and the tick counts as a wrap.
  - digit_en is sampled only on tick. If the current digit becomes disabled mid-slot, it stays shown until the next tick.
- Load:
  - On load, value and dp_in go into the pending registers and the pending flag sets. A repeated load overwrites pending (last wins).
  - On a wrap tick with pending = 1:
    - shadow <= pending; pending flag clears; update_ack pulses in the same cycle as the idx update.
    - The newly entered digit shows new data on that same cycle.
  - Load coinciding with a wrap-tick transfer: the transfer uses the old pending contents; the new load is written to pending and the flag stays 1, to be committed at the next wrap.
- frame_done: pulses on every wrap tick, whether or not a transfer occurs.
- Output timing:
  - active = idx.
  - num = shadow_value[4*idx +: 4].
  - dp_ctrl = ~shadow_dp[idx].
  - All three are registered-state derived with zero added latency, and change only on tick cycles or at reset.
- Reset mid-frame:
  - Pending data is discarded and the display returns to digit 0 showing 0.
  - The scan resumes with the first tick TICK_DIV cycles after release.

Decomposition:
- Shared package: NUM_DIGITS = 8, DIGIT_W = 4, IDX_W = 3, DEFAULT_TICK_DIV = 100000.
- Sub-module sseg_tick_gen: parameterized prescaler producing the tick pulse.
- The next-enabled-digit search is a combinational function in the main module.

Test Plan (TICK_DIV = 4):
- Reset then run, digit_en = 8'hFF, no load:
  - active steps 0,1,...,7,0 every 4 cycles; num = 0; dp_ctrl = 1.
  - frame_done pulses when active goes 7 -> 0.
- load with value = 32'h76543210, dp_in = 8'h01:
  - num is unchanged until the next wrap; then update_ack pulses.
  - num equals active on each digit; dp_ctrl = 0 only when active = 0.
- digit_en = 8'b1000_0101: active sequence is 0,2,7,0; frame_done pulses on each 7 -> 0 step.
- digit_en = 8'h10:
  - active stays 4.
  - frame_done pulses on every tick.
  - A pending load commits on the first tick.
- Load A = 32'h11111111, then load B = 32'h22222222 on the exact wrap-tick cycle:
  - That wrap shows A with update_ack = 1.
  - The next wrap shows B with a second update_ack.
- Assert reset_n = 0 mid-frame with a load pending:
  - Outputs go to their reset values immediately, asynchronously.
  - After release, no update_ack occurs and num stays 0.
